// File: rtl/wb_regfile_if.sv
// Writeback/read bus bundle for wb_regfile. The master drives the MEM/WB request and
// the read addresses; the slave (the register file) returns read data and status.
interface wb_regfile_if;
  logic        RegWrite_In;
  logic [1:0]  MemToReg_In;
  logic [31:0] RegDest_In;
  logic [31:0] ALUResult_In;
  logic [31:0] ReadData_In;
  logic [31:0] PCI_In;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData_Out;
  logic [31:0] WriteCount;
  logic [4:0]  LastWriteReg;
  logic [31:0] LastWriteData;

  modport master (
    output RegWrite_In, MemToReg_In, RegDest_In, ALUResult_In, ReadData_In, PCI_In,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, WriteData_Out, WriteCount, LastWriteReg, LastWriteData
  );

  modport slave (
    input  RegWrite_In, MemToReg_In, RegDest_In, ALUResult_In, ReadData_In, PCI_In,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, WriteData_Out, WriteCount, LastWriteReg, LastWriteData
  );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 writeback register file with commit counter and last-write capture.
// Define WB_REGFILE_BYPASS_EN to forward a pending commit onto the read ports in the same cycle.
module wb_regfile #(
  parameter logic [31:0] LINK_OFFSET = 32'd0
) (
  input logic         Clock,
  input logic         Reset,
  wb_regfile_if.slave bus
);

  logic [31:0] regs_q [32];
  logic [31:0] write_data;
  logic [4:0]  write_addr;
  logic        commit;
  logic [31:0] write_count_q, write_count_d;
  logic [4:0]  last_reg_q, last_reg_d;
  logic [31:0] last_data_q, last_data_d;
  logic [31:0] rd1, rd2;
  logic        unused_dest_hi;

  assign write_addr     = bus.RegDest_In[4:0];
  assign unused_dest_hi = ^bus.RegDest_In[31:5];

  always_comb begin
    write_data = 32'd0;
    case (bus.MemToReg_In)
      2'b00:   write_data = bus.ALUResult_In;
      2'b01:   write_data = bus.ReadData_In;
      2'b10:   write_data = bus.PCI_In + LINK_OFFSET;
      default: write_data = 32'd0;
    endcase
  end

  // Select 11 and register 0 are both silent no-ops, not just suppressed data writes.
  assign commit = bus.RegWrite_In && (bus.MemToReg_In != 2'b11) && (write_addr != 5'd0);

  always_comb begin
    write_count_d = write_count_q;
    last_reg_d    = last_reg_q;
    last_data_d   = last_data_q;
    if (commit) begin
      write_count_d = write_count_q + 32'd1;
      last_reg_d    = write_addr;
      last_data_d   = write_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      write_count_q <= 32'd0;
      last_reg_q    <= 5'd0;
      last_data_q   <= 32'd0;
    end else begin
      if (commit) regs_q[write_addr] <= write_data;
      write_count_q <= write_count_d;
      last_reg_q    <= last_reg_d;
      last_data_q   <= last_data_d;
    end
  end

  always_comb begin
    rd1 = (bus.ReadRegister1 == 5'd0) ? 32'd0 : regs_q[bus.ReadRegister1];
    rd2 = (bus.ReadRegister2 == 5'd0) ? 32'd0 : regs_q[bus.ReadRegister2];
`ifdef WB_REGFILE_BYPASS_EN
    // commit already excludes address 0, so the zero register is never bypassed.
    if (Reset && commit && (bus.ReadRegister1 == write_addr)) rd1 = write_data;
    if (Reset && commit && (bus.ReadRegister2 == write_addr)) rd2 = write_data;
`endif
  end

  assign bus.ReadData1     = rd1;
  assign bus.ReadData2     = rd2;
  assign bus.WriteData_Out = write_data;
  assign bus.WriteCount    = write_count_q;
  assign bus.LastWriteReg  = last_reg_q;
  assign bus.LastWriteData = last_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs from an array model,
// a monitor process pops and compares them against the live DUT outputs.
module tb_wb_regfile;

  localparam logic [31:0] LINK_OFF = 32'd4;
  localparam int K_WDATA = 0, K_RD1 = 1, K_RD2 = 2, K_WCNT = 3, K_LREG = 4, K_LDATA = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  wb_regfile_if bus ();
  wb_regfile #(.LINK_OFFSET(LINK_OFF)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  event        chk_ev;
  int          checks = 0;
  int          errors = 0;
  int          tag = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  logic [4:0]  m_lreg;
  logic [31:0] m_ldata;

  function automatic string kname(int k);
    case (k)
      K_WDATA: return "WriteData_Out";
      K_RD1:   return "ReadData1";
      K_RD2:   return "ReadData2";
      K_WCNT:  return "WriteCount";
      K_LREG:  return "LastWriteReg";
      default: return "LastWriteData";
    endcase
  endfunction

  function automatic logic [31:0] dut_val(int k);
    case (k)
      K_WDATA: return bus.WriteData_Out;
      K_RD1:   return bus.ReadData1;
      K_RD2:   return bus.ReadData2;
      K_WCNT:  return bus.WriteCount;
      K_LREG:  return {27'd0, bus.LastWriteReg};
      default: return bus.LastWriteData;
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = dut_val(e.kind);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s tag=%0d got=%h exp=%h", kname(e.kind), e.tag, got, e.exp);
        end
      end
    end
  end

  function automatic void push(int k, logic [31:0] v);
    exp_q.push_back('{kind: k, exp: v, tag: tag});
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] mtr, logic [31:0] alu, logic [31:0] ld,
                                          logic [31:0] pci);
    if (mtr == 2'd0) return alu;
    if (mtr == 2'd1) return ld;
    if (mtr == 2'd2) return pci + LINK_OFF;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, bit pending, logic [4:0] wa,
                                         logic [31:0] wd);
    if (Reset !== 1'b1 || a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (pending && a == wa) return wd;
`endif
    return m_regs[a];
  endfunction

  function automatic void m_clear();
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_count = 32'd0;
    m_lreg  = 5'd0;
    m_ldata = 32'd0;
  endfunction

  function automatic void push_status();
    push(K_WCNT, m_count);
    push(K_LREG, {27'd0, m_lreg});
    push(K_LDATA, m_ldata);
  endfunction

  // One bus cycle: drive at the falling edge, check pre-edge values, then advance the model.
  task automatic cycle(input bit rst, input bit rw, input logic [1:0] mtr, input logic [31:0] dest,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pci,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    logic [31:0] wd;
    bit          cm;
    @(negedge Clock);
    Reset             = rst;
    bus.RegWrite_In   = rw;
    bus.MemToReg_In   = mtr;
    bus.RegDest_In    = dest;
    bus.ALUResult_In  = alu;
    bus.ReadData_In   = ld;
    bus.PCI_In        = pci;
    bus.ReadRegister1 = ra1;
    bus.ReadRegister2 = ra2;
    #1;
    wd = m_wdata(mtr, alu, ld, pci);
    cm = rst && rw && (mtr != 2'b11) && (dest[4:0] != 5'd0);
    push(K_WDATA, wd);
    push(K_RD1, m_read(ra1, cm, dest[4:0], wd));
    push(K_RD2, m_read(ra2, cm, dest[4:0], wd));
    push_status();
    ->chk_ev;
    @(posedge Clock);
    if (cm) begin
      m_regs[dest[4:0]] = wd;
      m_count           = m_count + 32'd1;
      m_lreg            = dest[4:0];
      m_ldata           = wd;
    end
    tag++;
  endtask

  task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
    cycle(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, ra1, ra2);
  endtask

  initial begin : stim
    logic [31:0] dest;
    logic [4:0]  ra1, ra2;
    m_clear();
    bus.RegWrite_In = 1'b0; bus.MemToReg_In = 2'd0; bus.RegDest_In = 32'd0;
    bus.ALUResult_In = 32'd0; bus.ReadData_In = 32'd0; bus.PCI_In = 32'd0;
    bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;

    // Writes requested while held in reset must not land.
    cycle(1'b0, 1'b1, 2'd0, 32'd5, 32'h1111_1111, 32'd0, 32'd0, 5'd5, 5'd6);
    cycle(1'b0, 1'b1, 2'd1, 32'd6, 32'd0, 32'h2222_2222, 32'd0, 5'd5, 5'd6);
    // Release at a falling edge with a commit pending: the following rising edge commits.
    cycle(1'b1, 1'b1, 2'd0, 32'd7, 32'h7777_0007, 32'd0, 32'd0, 5'd5, 5'd7);
    idle(5'd7, 5'd5);

    // Basic write and read-back.
    cycle(1'b1, 1'b1, 2'd0, 32'd5, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd5, 5'd5);

    // Register 0 and illegal select.
    cycle(1'b1, 1'b1, 2'd0, 32'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd0, 5'd7);
    cycle(1'b1, 1'b1, 2'd3, 32'd7, 32'hFFFF_0000, 32'h5555_5555, 32'd0, 5'd0, 5'd7);
    idle(5'd0, 5'd7);

    // Link source with offset 4.
    cycle(1'b1, 1'b1, 2'd2, 32'd31, 32'd0, 32'd0, 32'h0040_0010, 5'd31, 5'd0);
    idle(5'd31, 5'd0);
    push(K_RD1, 32'h0040_0014);
    ->chk_ev;

    // Same-cycle read of the register being written.
    cycle(1'b1, 1'b1, 2'd0, 32'd9, 32'h1111_9999, 32'd0, 32'd0, 5'd0, 5'd9);
    cycle(1'b1, 1'b1, 2'd0, 32'd9, 32'hA5A5_A5A5, 32'd0, 32'd0, 5'd9, 5'd9);
    idle(5'd9, 5'd9);

    // Counter wrap: preload the count, then commit once.
    #1 force dut.write_count_q = 32'hFFFF_FFFF;
    #1 release dut.write_count_q;
    m_count = 32'hFFFF_FFFF;
    cycle(1'b1, 1'b1, 2'd1, 32'hFFFF_FFE3, 32'd0, 32'h3333_0003, 32'd0, 5'd3, 5'd0);
    idle(5'd3, 5'd3);

    // Randomised mix, biased toward same-address reads and legal writes.
    for (int n = 0; n < 300; n++) begin
      dest = $urandom;
      if ($urandom_range(0, 7) == 0) dest[4:0] = 5'd0;
      ra1 = ($urandom_range(0, 2) == 0) ? dest[4:0] : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? dest[4:0] : 5'($urandom);
      cycle(1'b1, ($urandom_range(0, 3) != 0), 2'($urandom), dest, $urandom, $urandom, $urandom,
            ra1, ra2);
    end

    // Fill every register, then drop reset between edges with a write pending.
    for (int r = 1; r < 32; r++)
      cycle(1'b1, 1'b1, 2'd0, r, 32'hC000_0000 | r, 32'd0, 32'd0, 5'(r - 1), 5'(r));
    @(negedge Clock);
    bus.RegWrite_In = 1'b1; bus.MemToReg_In = 2'd0; bus.RegDest_In = 32'd12;
    bus.ALUResult_In = 32'hCAFE_F00D;
    #2 Reset = 1'b0;
    m_clear();
    for (int a = 0; a < 32; a++) begin
      bus.ReadRegister1 = 5'(a);
      bus.ReadRegister2 = 5'(31 - a);
      #1;
      push(K_RD1, 32'd0);
      push(K_RD2, 32'd0);
      if (a == 0) push_status();
      ->chk_ev;
    end
    cycle(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd12, 5'd1);
    idle(5'd12, 5'd31);
    cycle(1'b1, 1'b1, 2'd0, 32'd12, 32'h0BAD_CAFE, 32'd0, 32'd0, 5'd12, 5'd0);
    idle(5'd12, 5'd0);

    #20;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have exactly one clock and one reset. The reset is asynchronous and active-low.
REQ-002 Parameter LINK_OFFSET SHALL default to 32'd0. It is the constant added to PCI_In for link writes.
REQ-003 Ports SHALL be exactly as follows:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- RegWrite_In  in  1  write request from the MEM/WB stage.
- MemToReg_In  in  2  writeback source select.
- RegDest_In  in  32  destination register; only bits [4:0] are used.
- ALUResult_In  in  32  ALU result.
- ReadData_In  in  32  memory load data.
- PCI_In  in  32  link PC value.
- ReadRegister1  in  5  read port 1 address.
- ReadRegister2  in  5  read port 2 address.
- ReadData1  out  32  read port 1 data.
- ReadData2  out  32  read port 2 data.
- WriteData_Out  out  32  selected writeback value, combinational, used for forwarding.
- WriteCount  out  32  count of committed writes.
- LastWriteReg  out  5  address of the most recent committed write.
- LastWriteData  out  32  data of the most recent committed write.

Function
REQ-004 WriteData_Out SHALL be selected by MemToReg_In as follows:
- 00: ALUResult_In.
- 01: ReadData_In.
- 10: PCI_In+LINK_OFFSET, mod 2^32.
- 11: 32'd0.
REQ-005 A commit SHALL occur at a rising Clock when all three hold: RegWrite_In=1, MemToReg_In!=11, and RegDest_In[4:0]!=0.
REQ-006 On a commit, the block SHALL write register[RegDest_In[4:0]] with WriteData_Out.
REQ-007 RegDest_In[31:5] SHALL be ignored. Bits [31:5] being nonzero SHALL neither block nor redirect a write.
REQ-008 Register 0 SHALL always read 0, and writes to it SHALL be discarded without a commit.
REQ-009 MemToReg_In=11 with RegWrite_In=1 SHALL be an illegal-select no-op: no register write, no commit.
REQ-010 Reads SHALL be combinational (zero latency) from the register array, on both ports independently.
REQ-011 Both read ports MAY address the same register; each port SHALL return the same value.
REQ-012 On a commit, WriteCount SHALL increment by 1 and wrap from 32'hFFFFFFFF to 0.
REQ-013 On a commit, LastWriteReg and LastWriteData SHALL capture the committed address and data.
REQ-014 Without a commit, WriteCount, LastWriteReg and LastWriteData SHALL hold their values.
REQ-015 A commit SHALL be visible on the read ports in the cycle after the commit edge.

Reset
REQ-016 When Reset=0, registers 1-31, WriteCount, LastWriteReg and LastWriteData SHALL clear to 0 immediately, independent of Clock.
REQ-017 While Reset=0, no commit SHALL occur, and ReadData1/ReadData2 SHALL return 0 for every address.
REQ-018 A reset asserted in the same cycle as a pending commit SHALL win. The write is lost and WriteCount stays 0.
REQ-019 Reset deassertion SHALL take effect on the next rising Clock. A commit requested at that edge SHALL be performed.

Configuration
REQ-020 The macro WB_REGFILE_BYPASS_EN SHALL control same-cycle read-after-write bypass.
REQ-021 With WB_REGFILE_BYPASS_EN defined: when a commit is pending and ReadRegisterN==RegDest_In[4:0] (nonzero), ReadDataN SHALL return WriteData_Out combinationally.
REQ-022 Without WB_REGFILE_BYPASS_EN: the read port SHALL return the pre-commit stored value, and the new value SHALL appear the next cycle.
REQ-023 The address-0 rule (REQ-008) SHALL hold in both configurations.

Verification
REQ-024 Basic write and read-back:
- Stimulus: RegWrite=1, MemToReg=00, RegDest=5, ALUResult=32'hDEADBEEF, one edge.
- Required response: ReadData1 at addr 5 = 32'hDEADBEEF; WriteCount=1; LastWriteReg=5.
REQ-025 Register 0 and illegal select:
- Stimulus: write RegDest=0 with ALUResult=32'h1234.
- Stimulus: write RegDest=7 with MemToReg=11.
- Required response: reg0 reads 0; reg7 unchanged; WriteCount unchanged.
REQ-026 Link source:
- Stimulus: LINK_OFFSET=4, MemToReg=10, PCI_In=32'h00400010, RegDest=31.
- Required response: reg31 = 32'h00400014.
REQ-027 Same-cycle bypass:
- Stimulus: write 32'hA5A5A5A5 to reg 9 while ReadRegister2=9 in the same cycle.
- Required response with WB_REGFILE_BYPASS_EN: ReadData2 = 32'hA5A5A5A5 pre-edge.
- Required response without it: old value pre-edge, 32'hA5A5A5A5 post-edge.
REQ-028 Asynchronous reset mid-operation:
- Stimulus: fill regs 1-31, then assert Reset low between edges.
- Required response: all reads = 0 and WriteCount = 0 before the next edge; a pending write is dropped.
REQ-029 Counter wrap and ignored high address bits:
- Stimulus: preload WriteCount to 32'hFFFFFFFF, then commit once.
- Required response: WriteCount = 0.
- Stimulus: commit with RegDest_In=32'hFFFFFFE3.
- Required response: the write targets reg 3.
